// File: rtl/aqua_pkg.sv
// aqua_pkg: shared types for the load/store unit.
//   mem_op_e    - load/store op encoding carried in mem_req_t.instr
//   lsu_state_e - LSU FSM states
//   mem_req_t   - AGU -> LSU request package
//   wb_t        - LSU -> register file writeback package
// Helpers classify ops and build store lanes / byte enables.
package aqua_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] target_addr;
        mem_op_e     instr;
        logic [31:0] data;
        logic [4:0]  rd_addr;
        logic        wr_en;
        logic        valid;
        logic        is_instr2;
    } mem_req_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        wr_en;
        logic        valid;
        logic        is_instr2;
    } wb_t;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always fine.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return (a != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input mem_op_e op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
            default:              return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes; be selects the live ones.
    function automatic logic [31:0] store_wdata(input mem_op_e op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load lane extraction and extension.
//   word - 32-bit read word from memory
//   addr - byte offset within the word
//   op   - load op (LB/LBU/LH/LHU/LW)
//   data - aligned, sign/zero-extended result
module lsu_load_align
    import aqua_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  mem_op_e     op,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Move the addressed byte/halfword down to bit 0.
    assign shifted = word >> {addr, 3'b000};

    always_comb begin
        data = shifted;
        case (op)
            OP_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  data = {24'h0, shifted[7:0]};
            OP_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  data = {16'h0, shifted[15:0]};
            // LW is only ever accepted word-aligned, so shifted == word.
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit.
//   i_clk, i_rst_n        - clock, async active-low reset
//   i_agu_lsu_pkg         - request from AGU (accepted when o_lsu_ready)
//   o_lsu_ready           - high only in IDLE
//   i_flush               - kills a pending load writeback
//   o_dmem_*/i_dmem_*     - data memory request/ack handshake
//   o_lsu_wb_pkg          - one-cycle load writeback
//   o_misalign, o_bus_err - one-cycle exception pulses
// MEM_TIMEOUT bounds how many cycles a request waits for ack.
module lsu
    import aqua_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  mem_req_t    i_agu_lsu_pkg,
    output logic        o_lsu_ready,
    input  logic        i_flush,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output wb_t         o_lsu_wb_pkg,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    lsu_state_e     state;
    mem_op_e        op_q;
    logic [1:0]     lane_q;
    logic [4:0]     rd_q;
    logic           wr_en_q;
    logic           instr2_q;
    logic           kill_q;
    logic [CNT_W-1:0] cnt_q;
    wb_t            wb_q;
    logic [31:0]    load_data;
    logic           accept;
    logic           misalign_acc;

    assign accept       = (state == IDLE) && i_agu_lsu_pkg.valid && !i_flush;
    assign misalign_acc = is_misaligned(i_agu_lsu_pkg.instr, i_agu_lsu_pkg.target_addr[1:0]);
    assign o_lsu_ready  = (state == IDLE);

    lsu_load_align u_align (
        .word (i_dmem_rdata),
        .addr (lane_q),
        .op   (op_q),
        .data (load_data)
    );

    // A flush in the WB cycle itself suppresses the registered valid.
    always_comb begin
        o_lsu_wb_pkg       = wb_q;
        o_lsu_wb_pkg.valid = wb_q.valid && !i_flush;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            op_q         <= OP_LB;
            lane_q       <= '0;
            rd_q         <= '0;
            wr_en_q      <= 1'b0;
            instr2_q     <= 1'b0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            wb_q         <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
            o_misalign   <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misalign_acc) begin
                            o_misalign <= 1'b1;
                        end else begin
                            state        <= REQ;
                            op_q         <= i_agu_lsu_pkg.instr;
                            lane_q       <= i_agu_lsu_pkg.target_addr[1:0];
                            rd_q         <= i_agu_lsu_pkg.rd_addr;
                            wr_en_q      <= i_agu_lsu_pkg.wr_en;
                            instr2_q     <= i_agu_lsu_pkg.is_instr2;
                            kill_q       <= 1'b0;
                            cnt_q        <= '0;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= is_store(i_agu_lsu_pkg.instr);
                            o_dmem_addr  <= {i_agu_lsu_pkg.target_addr[31:2], 2'b00};
                            o_dmem_wdata <= store_wdata(i_agu_lsu_pkg.instr, i_agu_lsu_pkg.data);
                            o_dmem_be    <= lane_be(i_agu_lsu_pkg.instr,
                                                    i_agu_lsu_pkg.target_addr[1:0]);
                        end
                    end
                end
                REQ: begin
                    // Ack wins over the timeout when both land on the same edge.
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        kill_q     <= 1'b0;
                        if (is_store(op_q)) begin
                            state <= IDLE;
                        end else begin
                            state             <= WB;
                            wb_q.valid        <= !(kill_q || i_flush);
                            wb_q.rd_data      <= load_data;
                            wb_q.rd_addr      <= rd_q;
                            wb_q.wr_en        <= wr_en_q && (rd_q != 5'd0);
                            wb_q.is_instr2    <= instr2_q;
                        end
                    end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        o_bus_err  <= 1'b1;
                        kill_q     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (i_flush) kill_q <= 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                    wb_q  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed, table-driven bench for lsu plus hand-written
// sequences for timeout, flush, and reset corner cases.
module tb_lsu;
    import aqua_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    mem_req_t    pkg;
    logic        o_lsu_ready;
    logic        i_flush;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    wb_t         wb;
    logic        o_misalign;
    logic        o_bus_err;

    int checks = 0;
    int errors = 0;

    lsu #(.MEM_TIMEOUT(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_agu_lsu_pkg (pkg),
        .o_lsu_ready   (o_lsu_ready),
        .i_flush       (i_flush),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_ack    (i_dmem_ack),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_lsu_wb_pkg  (wb),
        .o_misalign    (o_misalign),
        .o_bus_err     (o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        wr_en;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic [31:0] e_rd;
        logic        e_wren;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present a request for one edge; returns 1 time unit after the accept edge.
    task automatic drive_req(input mem_op_e op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] rd, input logic wr_en, input logic i2);
        pkg.instr       = op;
        pkg.target_addr = addr;
        pkg.data        = data;
        pkg.rd_addr     = rd;
        pkg.wr_en       = wr_en;
        pkg.is_instr2   = i2;
        pkg.valid       = 1'b1;
        tick();
        pkg.valid       = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_LB,  32'h103, 32'h0,        32'h80AABBCC, 5'd5,  1'b1, 32'h100, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
        vecs[1]  = '{OP_LBU, 32'h103, 32'h0,        32'h80AABBCC, 5'd6,  1'b1, 32'h100, 4'b1000, 32'h0,        1'b0, 32'h00000080, 1'b1};
        vecs[2]  = '{OP_LB,  32'h101, 32'h0,        32'h80AABBCC, 5'd7,  1'b1, 32'h100, 4'b0010, 32'h0,        1'b0, 32'hFFFFFFBB, 1'b1};
        vecs[3]  = '{OP_LH,  32'h202, 32'h0,        32'h80AABBCC, 5'd8,  1'b1, 32'h200, 4'b1100, 32'h0,        1'b0, 32'hFFFF80AA, 1'b1};
        vecs[4]  = '{OP_LHU, 32'h200, 32'h0,        32'h80AABBCC, 5'd9,  1'b0, 32'h200, 4'b0011, 32'h0,        1'b0, 32'h0000BBCC, 1'b0};
        vecs[5]  = '{OP_LH,  32'h200, 32'h0,        32'h12347FFF, 5'd10, 1'b1, 32'h200, 4'b0011, 32'h0,        1'b0, 32'h00007FFF, 1'b1};
        vecs[6]  = '{OP_LW,  32'h010, 32'h0,        32'hDEADBEEF, 5'd0,  1'b1, 32'h010, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{OP_SH,  32'h202, 32'h1234ABCD, 32'h0,        5'd1,  1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{OP_SB,  32'h301, 32'h000000A5, 32'h0,        5'd1,  1'b0, 32'h300, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{OP_SW,  32'h404, 32'hCAFEF00D, 32'h0,        5'd1,  1'b0, 32'h404, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vecs[10] = '{OP_LW,  32'h006, 32'h0,        32'h0,        5'd2,  1'b1, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
        vecs[11] = '{OP_SH,  32'h203, 32'h0,        32'h0,        5'd2,  1'b0, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
        vecs[12] = '{OP_LBU, 32'h000, 32'h0,        32'h000000FF, 5'd31, 1'b1, 32'h000, 4'b0001, 32'h0,        1'b0, 32'h000000FF, 1'b1};
        vecs[13] = '{OP_SB,  32'h003, 32'h00000077, 32'h0,        5'd1,  1'b0, 32'h000, 4'b1000, 32'h77777777, 1'b0, 32'h0,        1'b0};

        pkg          = '0;
        i_flush      = 1'b0;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = '0;
        i_rst_n      = 1'b0;

        // Reset state
        #2;
        chk("rst_ready",   o_lsu_ready, 1);
        chk("rst_req",     o_dmem_req,  0);
        chk("rst_wbvalid", wb.valid,    0);
        chk("rst_mis",     o_misalign,  0);
        chk("rst_buserr",  o_bus_err,   0);
        chk("rst_addr",    o_dmem_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Table-driven single transactions, ack in the first REQ cycle
        for (int i = 0; i < 14; i++) begin
            drive_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].wr_en, 1'(i % 2));
            if (vecs[i].e_mis) begin
                chk($sformatf("v%0d_mis", i),       o_misalign,  1);
                chk($sformatf("v%0d_mis_req", i),   o_dmem_req,  0);
                chk($sformatf("v%0d_mis_rdy", i),   o_lsu_ready, 1);
                tick();
                chk($sformatf("v%0d_mis_clr", i),   o_misalign,  0);
                chk($sformatf("v%0d_mis_req2", i),  o_dmem_req,  0);
            end else begin
                chk($sformatf("v%0d_req", i),   o_dmem_req,  1);
                chk($sformatf("v%0d_addr", i),  o_dmem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d_we", i),    o_dmem_we,   32'(vecs[i].op inside {OP_SB, OP_SH, OP_SW}));
                chk($sformatf("v%0d_rdy", i),   o_lsu_ready, 0);
                if (vecs[i].op inside {OP_SB, OP_SH, OP_SW}) begin
                    chk($sformatf("v%0d_be", i),    o_dmem_be,    vecs[i].e_be);
                    chk($sformatf("v%0d_wdata", i), o_dmem_wdata, vecs[i].e_wdata);
                end
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = vecs[i].rdata;
                tick();
                i_dmem_ack   = 1'b0;
                chk($sformatf("v%0d_req_drop", i), o_dmem_req, 0);
                if (vecs[i].op inside {OP_SB, OP_SH, OP_SW}) begin
                    chk($sformatf("v%0d_st_nowb", i), wb.valid,    0);
                    chk($sformatf("v%0d_st_rdy", i),  o_lsu_ready, 1);
                end else begin
                    chk($sformatf("v%0d_wbv", i),    wb.valid,     1);
                    chk($sformatf("v%0d_data", i),   wb.rd_data,   vecs[i].e_rd);
                    chk($sformatf("v%0d_rd", i),     wb.rd_addr,   32'(vecs[i].rd));
                    chk($sformatf("v%0d_wren", i),   wb.wr_en,     32'(vecs[i].e_wren));
                    chk($sformatf("v%0d_i2", i),     wb.is_instr2, 32'(i % 2));
                    tick();
                    chk($sformatf("v%0d_wb_end", i), wb.valid,     0);
                    chk($sformatf("v%0d_ld_rdy", i), o_lsu_ready,  1);
                end
            end
        end

        // Timeout: ack withheld, MEM_TIMEOUT=4
        drive_req(OP_LW, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to_req_c%0d", c), o_dmem_req, 1);
            chk($sformatf("to_err_c%0d", c), o_bus_err,  0);
            tick();
        end
        chk("to_req_drop", o_dmem_req,  0);
        chk("to_buserr",   o_bus_err,   1);
        chk("to_ready",    o_lsu_ready, 1);
        chk("to_nowb",     wb.valid,    0);
        tick();
        chk("to_err_clr",  o_bus_err,   0);
        chk("to_nowb2",    wb.valid,    0);

        // Ack on the threshold cycle counts as success
        drive_req(OP_LW, 32'hA0, 32'h0, 5'd9, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        chk("thr_req", o_dmem_req, 1);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h11223344;
        tick();
        i_dmem_ack   = 1'b0;
        chk("thr_noerr", o_bus_err,  0);
        chk("thr_wbv",   wb.valid,   1);
        chk("thr_data",  wb.rd_data, 32'h11223344);
        chk("thr_i2",    wb.is_instr2, 1);
        tick();

        // Flush in first REQ cycle, ack 3 cycles later
        drive_req(OP_LW, 32'h80, 32'h0, 5'd7, 1'b1, 1'b0);
        i_flush = 1'b1;
        chk("fl_req1", o_dmem_req, 1);
        tick();
        i_flush = 1'b0;
        chk("fl_req2", o_dmem_req, 1);
        tick();
        chk("fl_req3", o_dmem_req, 1);
        tick();
        chk("fl_req4", o_dmem_req, 1);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h55667788;
        tick();
        i_dmem_ack   = 1'b0;
        chk("fl_req_drop", o_dmem_req,  0);
        chk("fl_wb_kill",  wb.valid,    0);
        chk("fl_in_wb",    o_lsu_ready, 0);
        tick();
        chk("fl_ready", o_lsu_ready, 1);
        drive_req(OP_LBU, 32'h81, 32'h0, 5'd4, 1'b1, 1'b0);
        chk("fl_next_req", o_dmem_req, 1);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h00005A00;
        tick();
        i_dmem_ack   = 1'b0;
        chk("fl_next_wbv",  wb.valid,   1);
        chk("fl_next_data", wb.rd_data, 32'h0000005A);
        tick();

        // Flush during WB suppresses valid that cycle only
        drive_req(OP_LW, 32'h90, 32'h0, 5'd3, 1'b1, 1'b0);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h0BADF00D;
        tick();
        i_dmem_ack   = 1'b0;
        i_flush      = 1'b1;
        #1;
        chk("wbfl_kill", wb.valid, 0);
        i_flush      = 1'b0;
        #1;
        chk("wbfl_unflushed", wb.valid, 1);
        tick();
        chk("wbfl_ready", o_lsu_ready, 1);

        // Reset mid-REQ
        drive_req(OP_LW, 32'hB0, 32'h0, 5'd4, 1'b1, 1'b0);
        chk("rr_req", o_dmem_req, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rr_req_drop", o_dmem_req,  0);
        chk("rr_ready",    o_lsu_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hFFFFFFFF;
        tick();
        i_dmem_ack   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rr_nowb_c%0d", c),  wb.valid,    0);
            chk($sformatf("rr_noreq_c%0d", c), o_dmem_req,  0);
            chk($sformatf("rr_rdy_c%0d", c),   o_lsu_ready, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 64, max cycles o_dmem_req is held without i_dmem_ack before bus error.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_agu_lsu_pkg  input  mem_req_t  AGU request: target_addr, instr (load/store op), data (store data), rd_addr, wr_en, valid, is_instr2.
REQ-005 o_lsu_ready  output  1  LSU can accept a request this cycle.
REQ-006 i_flush  input  1  pipeline flush; kills pending load writeback.
REQ-007 o_dmem_req / o_dmem_we  output  1 / 1  memory request valid; write (store) when 1.
REQ-008 o_dmem_addr  output  32  word address, target_addr with [1:0] forced to 0.
REQ-009 o_dmem_wdata / o_dmem_be  output  32 / 4  lane-replicated store data; byte enables.
REQ-010 i_dmem_ack / i_dmem_rdata  input  1 / 32  memory completion; read word, valid when ack is high.
REQ-011 o_lsu_wb_pkg  output  wb_t  writeback: rd_addr, rd_data, wr_en, valid, is_instr2.
REQ-012 o_misalign / o_bus_err  output  1 / 1  one-cycle exception pulses.

Function
REQ-013 FSM states are IDLE, REQ and WB; o_lsu_ready SHALL be 1 only in IDLE.
REQ-014 Accept when IDLE, valid=1 and i_flush=0: capture the package on that edge and go to REQ; valid with i_flush=1 is dropped.
REQ-015 Misaligned accept (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL stay IDLE, issue no memory access, and pulse o_misalign the next cycle.
REQ-016 REQ: o_dmem_req=1 with stable addr/we/wdata/be until the edge where i_dmem_ack=1; ack may arrive in the first REQ cycle.
REQ-017 On ack: a store goes to IDLE; a load registers the aligned and extended data and goes to WB.
REQ-018 WB lasts exactly one cycle: o_lsu_wb_pkg.valid=1, rd_data = extracted data, wr_en = captured wr_en AND rd_addr!=0; then IDLE.
REQ-019 Minimum load latency: accept edge N, req in cycle N+1, wb valid in cycle N+2; back-to-back accepts every 3 cycles (stores every 2).
REQ-020 Store lanes: SB replicates data[7:0] x4, be=1<<addr[1:0]; SH replicates data[15:0] x2, be=0011 (addr[1]=0) or 1100; SW be=1111.
REQ-021 Load extract: lane = addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-022 Timeout counter SHALL clear on entry to REQ; if it reaches MEM_TIMEOUT without ack, drop o_dmem_req, pulse o_bus_err, return to IDLE with no writeback.
REQ-023 i_flush in REQ SHALL set a kill flag: the memory transaction still completes (stores are committed), and the load WB cycle is forced to valid=0.
REQ-024 i_flush during WB SHALL force o_lsu_wb_pkg.valid=0 that cycle.
REQ-025 Ack arriving in the same cycle as the timeout threshold SHALL count as success; ack outside REQ is ignored.
REQ-026 is_instr2 and rd_addr SHALL propagate unchanged from capture to writeback.

Reset
REQ-027 i_rst_n low SHALL immediately force state IDLE, kill flag 0, counter 0, and every output 0 except o_lsu_ready=1.
REQ-028 Reset mid-REQ SHALL drop o_dmem_req asynchronously; the abandoned transaction produces no writeback after reset is released.

Structure
REQ-029 aqua_pkg SHALL hold wb_t, lsu_state_e and the load/store op encoding carried in mem_req_t.instr; MEM_TIMEOUT stays a module parameter.
REQ-030 Load lane extraction and extension SHALL be the combinational sub-module lsu_load_align (inputs: word, addr[1:0], op; output: 32-bit data).

Verification
REQ-031 LB addr 0x103, ack at once, rdata 0x80AA_BBCC -> wb cycle N+2: rd_data 0xFFFF_FF80, valid=1.
REQ-032 SH addr 0x202, data 0x1234_ABCD -> o_dmem_addr 0x200, be 1100, wdata 0xABCD_ABCD, no wb.
REQ-033 LW addr 0x006 -> o_misalign pulse, o_dmem_req stays 0, o_lsu_ready stays 1.
REQ-034 LW with ack withheld, MEM_TIMEOUT=4 -> req high 4 cycles, then o_bus_err pulse, IDLE, no wb.
REQ-035 LW, i_flush in first REQ cycle, ack 3 cycles later -> transaction completes, wb valid=0; next request accepted.
REQ-036 i_rst_n low during REQ -> o_dmem_req 0 the same cycle, o_lsu_ready 1, no wb after release.
